// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : pwm_pkg                                                      |
// | Purpose : Types and helpers shared by pwm_timebase and the config      |
// |           sequencer: FSM state encoding, period sanitising and duty    |
// |           clamping.                                                    |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package pwm_pkg;

   // Helpers work on a wide value type so that any CNT_WIDTH up to 64 can
   // share them; callers zero-extend on the way in and truncate on the way out.
   localparam int unsigned PWM_VAL_W = 64;
   typedef logic [PWM_VAL_W-1:0] pwm_val_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } pwm_seq_state_t;

   // 0 selects the default period; 1 is bumped to 2 because a single-cycle
   // period would leave no room for a low phase.
   function automatic pwm_val_t pwm_period_eff(input pwm_val_t raw, input pwm_val_t dflt);
      pwm_val_t r;
      if (raw == '0)
         r = dflt;
      else if (raw == pwm_val_t'(1))
         r = pwm_val_t'(2);
      else
         r = raw;
      return r;
   endfunction

   // duty == period means 100% high; anything larger saturates there.
   function automatic pwm_val_t pwm_duty_clamp(input pwm_val_t duty, input pwm_val_t period);
      return (duty > period) ? period : duty;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_cfg_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : pwm_cfg_sequencer_if                                       |
// | Purpose   : Valid/ready configuration port of pwm_cfg_sequencer.       |
// | Signals   : cfg_valid  - new config offered (master -> slave)          |
// |             cfg_ready  - config accepted this cycle (slave -> master)  |
// |             cfg_period - requested period, raw                         |
// |             cfg_duty   - per-channel high time, ch i at [i*W +: W]     |
// |             cfg_run    - 1 = run after commit, 0 = stop                |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface pwm_cfg_sequencer_if #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned NUM_CH    = 4
) ();
   logic                        cfg_valid;
   logic                        cfg_ready;
   logic [CNT_WIDTH-1:0]        cfg_period;
   logic [NUM_CH*CNT_WIDTH-1:0] cfg_duty;
   logic                        cfg_run;

   modport master (
      output cfg_valid, cfg_period, cfg_duty, cfg_run,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_duty, cfg_run,
      output cfg_ready
   );
endinterface
`default_nettype wire

// File: rtl/pwm_shadow_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pwm_shadow_reg                                               |
// | Purpose : Shadow/active register pair. The shadow captures a value     |
// |           ahead of time; the active copy changes only on commit (from  |
// |           the shadow) or on a direct load (from d).                    |
// | Ports   : clk, rst_n    - clock, async active-low reset                |
// |           load_shadow   - shadow <= d                                  |
// |           commit        - active <= shadow                             |
// |           load_direct   - active <= d (wins over commit)               |
// |           d             - input value                                  |
// |           active_q      - active value                                 |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pwm_shadow_reg #(
   parameter int unsigned          WIDTH     = 32,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_shadow,
   input  logic             commit,
   input  logic             load_direct,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] active_q
);
   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] active_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (load_shadow)
         shadow_d = d;
      if (load_direct)
         active_d = d;
      else if (commit)
         active_d = shadow_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= RESET_VAL;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pwm_timebase                                                 |
// | Purpose : Free-running period counter. Counts 0..period_eff-1 while    |
// |           enabled, holds 0 while disabled, flags the last count.       |
// | Ports   : clk, rst_n     - clock, async active-low reset               |
// |           enable         - run the counter                             |
// |           period_cycles  - period in cycles (sanitised here as well)   |
// |           cnt            - current count                               |
// |           period_end     - high on the last count of a period          |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_WIDTH             = 32,
   parameter int unsigned DEFAULT_PERIOD_CYCLES = 5000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] period_cycles,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 period_end
);
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic [CNT_WIDTH-1:0] last_cnt;

   assign last_cnt = CNT_WIDTH'(pwm_period_eff(pwm_val_t'(period_cycles),
                                               pwm_val_t'(DEFAULT_PERIOD_CYCLES))
                                - pwm_val_t'(1));

   // >= rather than == so a count stranded above a shorter period still wraps.
   assign period_end = enable & (cnt_q >= last_cnt);
   assign cnt        = cnt_q;

   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (!enable || period_end)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule
`default_nettype wire

// File: rtl/pwm_cfg_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pwm_cfg_sequencer                                            |
// | Purpose : Owns period/duty/run configuration of one pwm_timebase and   |
// |           its duty comparators. Settings arriving while stopped apply  |
// |           on the next clock; settings arriving while running wait in   |
// |           shadow registers and commit at a period_end boundary, so no  |
// |           period is ever truncated.                                    |
// | Ports   : clk, rst_n        - clock, async active-low reset            |
// |           cfg (slave)       - valid/ready config port                  |
// |           period_end        - last count of period, from timebase      |
// |           tb_enable         - timebase enable                          |
// |           tb_period_cycles  - effective active period                  |
// |           duty_active       - effective active duties, clamped         |
// |           pending           - shadow loaded, waiting for boundary      |
// |           commit_pulse      - 1-cycle strobe while new values are live |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module pwm_cfg_sequencer
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_WIDTH             = 32,
   parameter int unsigned NUM_CH                = 4,
   parameter int unsigned DEFAULT_PERIOD_CYCLES = 5000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pwm_cfg_sequencer_if.slave          cfg,
   input  logic                        period_end,
   output logic                        tb_enable,
   output logic [CNT_WIDTH-1:0]        tb_period_cycles,
   output logic [NUM_CH*CNT_WIDTH-1:0] duty_active,
   output logic                        pending,
   output logic                        commit_pulse
);
   localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);

   pwm_seq_state_t state_q, state_d;
   logic ready_q, ready_d;
   logic pending_q, pending_d;
   logic commit_q, commit_d;
   logic pend_run_q, pend_run_d;   // run bit of the waiting config, picks RUN/IDLE at commit

   logic accept;
   logic load_direct;
   logic load_shadow;
   logic commit;

   logic [CNT_WIDTH-1:0]        period_eff;
   logic [NUM_CH*CNT_WIDTH-1:0] duty_eff;

   assign accept = cfg.cfg_valid & ready_q;

   // Sanitised on the way in so shadow and active copies only ever hold legal values.
   assign period_eff = CNT_WIDTH'(pwm_period_eff(pwm_val_t'(cfg.cfg_period),
                                                 pwm_val_t'(DEFAULT_PERIOD_CYCLES)));

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      pend_run_d  = pend_run_q;
      load_direct = 1'b0;
      load_shadow = 1'b0;
      commit      = 1'b0;
      case (state_q)
         IDLE: begin
            // Timebase is stopped, so updating active values now cannot glitch.
            if (accept) begin
               load_direct = 1'b1;
               state_d     = cfg.cfg_run ? RUN : IDLE;
            end
         end
         RUN: begin
            // A period_end on this same edge is deliberately ignored: the
            // commit waits a whole period, decided in PENDING from the next edge.
            if (accept) begin
               load_shadow = 1'b1;
               pending_d   = 1'b1;
               pend_run_d  = cfg.cfg_run;
               state_d     = PENDING;
            end
         end
         PENDING: begin
            if (period_end) begin
               commit    = 1'b1;
               pending_d = 1'b0;
               state_d   = pend_run_q ? RUN : IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = 1'b0;
         end
      endcase
      ready_d  = (state_d != PENDING);
      commit_d = load_direct | commit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         pending_q  <= 1'b0;
         commit_q   <= 1'b0;
         pend_run_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         pending_q  <= pending_d;
         commit_q   <= commit_d;
         pend_run_q <= pend_run_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign pending       = pending_q;
   assign commit_pulse  = commit_q;

   pwm_shadow_reg #(
      .WIDTH     (CNT_WIDTH),
      .RESET_VAL (RST_PERIOD)
   ) u_period (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_shadow (load_shadow),
      .commit      (commit),
      .load_direct (load_direct),
      .d           (period_eff),
      .active_q    (tb_period_cycles)
   );

   pwm_shadow_reg #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_run (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_shadow (load_shadow),
      .commit      (commit),
      .load_direct (load_direct),
      .d           (cfg.cfg_run),
      .active_q    (tb_enable)
   );

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign duty_eff[i*CNT_WIDTH +: CNT_WIDTH] =
            CNT_WIDTH'(pwm_duty_clamp(pwm_val_t'(cfg.cfg_duty[i*CNT_WIDTH +: CNT_WIDTH]),
                                      pwm_val_t'(period_eff)));

         pwm_shadow_reg #(
            .WIDTH     (CNT_WIDTH),
            .RESET_VAL ('0)
         ) u_duty (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_shadow (load_shadow),
            .commit      (commit),
            .load_direct (load_direct),
            .d           (duty_eff[i*CNT_WIDTH +: CNT_WIDTH]),
            .active_q    (duty_active[i*CNT_WIDTH +: CNT_WIDTH])
         );
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pwm_cfg_sequencer                                         |
// | Purpose : Directed self-checking bench for pwm_cfg_sequencer driving   |
// |           a real pwm_timebase. Inputs change and outputs are sampled   |
// |           on the falling edge.                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_pwm_cfg_sequencer;
   localparam int unsigned CW  = 32;
   localparam int unsigned NC  = 4;
   localparam int unsigned DEF = 5000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_cfg_sequencer_if #(.CNT_WIDTH(CW), .NUM_CH(NC)) cfg_if ();

   logic             period_end;
   logic             tb_enable;
   logic [CW-1:0]    tb_period_cycles;
   logic [NC*CW-1:0] duty_active;
   logic             pending;
   logic             commit_pulse;
   logic [CW-1:0]    cnt;

   pwm_cfg_sequencer #(
      .CNT_WIDTH             (CW),
      .NUM_CH                (NC),
      .DEFAULT_PERIOD_CYCLES (DEF)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg              (cfg_if.slave),
      .period_end       (period_end),
      .tb_enable        (tb_enable),
      .tb_period_cycles (tb_period_cycles),
      .duty_active      (duty_active),
      .pending          (pending),
      .commit_pulse     (commit_pulse)
   );

   pwm_timebase #(
      .CNT_WIDTH             (CW),
      .DEFAULT_PERIOD_CYCLES (DEF)
   ) u_timebase (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (tb_enable),
      .period_cycles (tb_period_cycles),
      .cnt           (cnt),
      .period_end    (period_end)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic logic [CW-1:0] duty(input int i);
      return duty_active[i*CW +: CW];
   endfunction

   // Offer one config at a falling edge; it is taken on the next rising edge.
   task automatic offer(input logic [CW-1:0] p, input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                        input logic [CW-1:0] d2, input logic [CW-1:0] d3, input logic run);
      check("ready_at_offer", 64'(cfg_if.cfg_ready), 64'd1);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = p;
      cfg_if.cfg_duty   = {d3, d2, d1, d0};
      cfg_if.cfg_run    = run;
      @(negedge clk);
      cfg_if.cfg_valid  = 1'b0;
   endtask

   // Number of falling edges until period_end is seen high.
   task automatic wait_pe(input string tag, input int exp);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_end && n < 6000);
      check(tag, 64'(n), 64'(exp));
   endtask

   task automatic wait_cnt(input string tag, input logic [CW-1:0] v);
      for (int k = 0; k < 50 && cnt != v; k++)
         @(negedge clk);
      check(tag, 64'(cnt), 64'(v));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic saw;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_period = '0;
      cfg_if.cfg_duty   = '0;
      cfg_if.cfg_run    = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ready",   64'(cfg_if.cfg_ready), 64'd0);
      check("rst_enable",  64'(tb_enable), 64'd0);
      check("rst_period",  64'(tb_period_cycles), 64'(DEF));
      check("rst_duty",    64'(duty_active == '0), 64'd1);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_commit",  64'(commit_pulse), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 64'(cfg_if.cfg_ready), 64'd1);

      // 1: IDLE accept applies on the next clock
      offer(10, 3, 15, 10, 0, 1'b1);
      check("t1_enable", 64'(tb_enable), 64'd1);
      check("t1_period", 64'(tb_period_cycles), 64'd10);
      check("t1_duty0",  64'(duty(0)), 64'd3);
      check("t1_duty1_clamp", 64'(duty(1)), 64'd10);
      check("t1_duty2_full",  64'(duty(2)), 64'd10);
      check("t1_duty3",  64'(duty(3)), 64'd0);
      check("t1_commit", 64'(commit_pulse), 64'd1);
      check("t1_pending", 64'(pending), 64'd0);
      check("t1_cnt",    64'(cnt), 64'd0);
      @(negedge clk);
      check("t1_commit_drop", 64'(commit_pulse), 64'd0);
      wait_pe("t1_first_pe", 8);
      wait_pe("t1_spacing", 10);

      // 2: RUN write at cnt=4 waits for the boundary
      wait_cnt("t2_cnt4", 4);
      offer(20, 7, 0, 0, 0, 1'b1);
      check("t2_pending", 64'(pending), 64'd1);
      check("t2_ready",   64'(cfg_if.cfg_ready), 64'd0);
      check("t2_period_held", 64'(tb_period_cycles), 64'd10);
      check("t2_no_commit", 64'(commit_pulse), 64'd0);
      wait_pe("t2_old_tail", 4);
      check("t2_period_at_pe", 64'(tb_period_cycles), 64'd10);
      @(negedge clk);
      check("t2_period_new", 64'(tb_period_cycles), 64'd20);
      check("t2_duty0_new",  64'(duty(0)), 64'd7);
      check("t2_commit",     64'(commit_pulse), 64'd1);
      check("t2_pending_clr", 64'(pending), 64'd0);
      check("t2_ready_back", 64'(cfg_if.cfg_ready), 64'd1);
      check("t2_cnt0",       64'(cnt), 64'd0);
      wait_pe("t2_new_first", 19);
      wait_pe("t2_new_spacing", 20);

      // 3: accept on the same edge as period_end commits one full period later
      offer(10, 3, 0, 0, 0, 1'b1);
      check("t3_pending", 64'(pending), 64'd1);
      check("t3_period_held", 64'(tb_period_cycles), 64'd20);
      check("t3_cnt0", 64'(cnt), 64'd0);
      wait_pe("t3_full_period", 19);
      check("t3_period_at_pe", 64'(tb_period_cycles), 64'd20);
      @(negedge clk);
      check("t3_period_new", 64'(tb_period_cycles), 64'd10);
      check("t3_commit", 64'(commit_pulse), 64'd1);

      // 5: stop at cnt=2 completes the current period
      wait_cnt("t5_cnt2", 2);
      offer(10, 3, 0, 0, 0, 1'b0);
      check("t5_pending", 64'(pending), 64'd1);
      check("t5_enable_held", 64'(tb_enable), 64'd1);
      wait_pe("t5_drain", 6);
      check("t5_enable_at_pe", 64'(tb_enable), 64'd1);
      @(negedge clk);
      check("t5_enable_off", 64'(tb_enable), 64'd0);
      check("t5_cnt0",   64'(cnt), 64'd0);
      check("t5_ready",  64'(cfg_if.cfg_ready), 64'd1);
      check("t5_commit", 64'(commit_pulse), 64'd1);
      @(negedge clk);
      check("t5_cnt_stays0", 64'(cnt), 64'd0);

      // 4: clamping in IDLE
      offer(0, 6000, 0, 0, 0, 1'b0);
      check("t4_p0_period", 64'(tb_period_cycles), 64'd5000);
      check("t4_p0_duty0",  64'(duty(0)), 64'd5000);
      check("t4_p0_enable", 64'(tb_enable), 64'd0);
      offer(1, 1, 3, 0, 0, 1'b0);
      check("t4_p1_period", 64'(tb_period_cycles), 64'd2);
      check("t4_p1_duty0",  64'(duty(0)), 64'd1);
      check("t4_p1_duty1",  64'(duty(1)), 64'd2);
      offer(10, 15, 0, 0, 0, 1'b0);
      check("t4_p10_duty0", 64'(duty(0)), 64'd10);

      // 6: reset during PENDING
      offer(10, 0, 0, 0, 0, 1'b1);
      offer(30, 5, 0, 0, 0, 1'b1);
      check("t6_pending", 64'(pending), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_enable",  64'(tb_enable), 64'd0);
      check("t6_async_period",  64'(tb_period_cycles), 64'(DEF));
      check("t6_async_pending", 64'(pending), 64'd0);
      check("t6_async_ready",   64'(cfg_if.cfg_ready), 64'd0);
      check("t6_async_duty",    64'(duty_active == '0), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (35) begin
         @(negedge clk);
         saw = saw | commit_pulse | pending | tb_enable;
      end
      check("t6_no_commit", 64'(saw), 64'd0);
      check("t6_period_after", 64'(tb_period_cycles), 64'(DEF));
      offer(12, 4, 0, 0, 0, 1'b0);
      check("t6_idle_direct", 64'(tb_period_cycles), 64'd12);
      check("t6_idle_commit", 64'(commit_pulse), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
